// File: rtl/axi_lite_cmd_master.sv
// axi_lite_cmd_master
//   AXI4-Lite initiator. Turns one fabric command (addr, data, strobe, rd/wr)
//   into one AXI4-Lite transaction and returns read data plus response.
//   Only one transaction is outstanding at a time.
//
// Ports
//   ACLK, ARESETN          clock (rising edge), async active-low reset
//   cmd_*                  command in (valid/ready), write flag, addr, data, strobes
//   rsp_*                  response out (valid/ready), read data, resp code
//   M_AXI_AW*/W*/B*        AXI4-Lite write channels
//   M_AXI_AR*/R*           AXI4-Lite read channels
//   err_count              non-OKAY response counter, saturating
//                          (present only when AXIL_ERRCNT_EN is defined)
//
// Build option
//   AXIL_ERRCNT_EN         adds ERRCNT_WIDTH parameter, err_count port and counter
module axi_lite_cmd_master #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] ADDR_BASE = '0
`ifdef AXIL_ERRCNT_EN
  , parameter int ERRCNT_WIDTH = 16
`endif
) (
  input  logic                              ACLK,
  input  logic                              ARESETN,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic                              cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                        rsp_resp,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic [2:0]                        M_AXI_AWPROT,
  output logic                              M_AXI_AWVALID,
  input  logic                              M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                              M_AXI_WVALID,
  input  logic                              M_AXI_WREADY,
  input  logic [1:0]                        M_AXI_BRESP,
  input  logic                              M_AXI_BVALID,
  output logic                              M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic [2:0]                        M_AXI_ARPROT,
  output logic                              M_AXI_ARVALID,
  input  logic                              M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                        M_AXI_RRESP,
  input  logic                              M_AXI_RVALID,
  output logic                              M_AXI_RREADY
`ifdef AXIL_ERRCNT_EN
  , output logic [ERRCNT_WIDTH-1:0]         err_count
`endif
);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP} state_t;

  state_t state, state_nxt;

  logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q;
  logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_q, rdata_q;
  logic [C_M_AXI_DATA_WIDTH/8-1:0] wstrb_q;
  logic [1:0]                      resp_q;
  logic awvalid_q, wvalid_q, arvalid_q, bready_q, rready_q, rsp_valid_q;
  logic accept, aw_nxt, w_nxt, b_hs, r_hs;

  assign accept = (state == IDLE) && cmd_valid;
  // AW and W complete independently; each valid stays up until its own handshake
  assign aw_nxt = awvalid_q & ~M_AXI_AWREADY;
  assign w_nxt  = wvalid_q  & ~M_AXI_WREADY;
  assign b_hs   = bready_q & M_AXI_BVALID;
  assign r_hs   = rready_q & M_AXI_RVALID;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_valid) state_nxt = cmd_write ? WR_REQ : RD_REQ;
      WR_REQ:  if (!aw_nxt && !w_nxt) state_nxt = WR_RESP;
      WR_RESP: if (b_hs) state_nxt = RSP;
      RD_REQ:  if (M_AXI_ARREADY) state_nxt = RD_DATA;
      RD_DATA: if (r_hs) state_nxt = RSP;
      RSP:     if (rsp_valid_q && rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state       <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rdata_q     <= '0;
      resp_q      <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      awvalid_q <= (accept && cmd_write) | aw_nxt;
      wvalid_q  <= (accept && cmd_write) | w_nxt;
      arvalid_q <= (accept && !cmd_write) | (arvalid_q & ~M_AXI_ARREADY);
      // READY only while waiting for the response, so early B/R valids just wait
      bready_q  <= (state_nxt == WR_RESP);
      rready_q  <= (state_nxt == RD_DATA);
      // rsp_valid rises the cycle after capture and drops on its handshake
      rsp_valid_q <= (state == RSP) && (state_nxt == RSP);
      if (accept) begin
        addr_q  <= cmd_addr + ADDR_BASE;
        wdata_q <= cmd_wdata;
        wstrb_q <= cmd_wstrb;
      end
      if (b_hs) begin
        rdata_q <= '0;
        resp_q  <= M_AXI_BRESP;
      end else if (r_hs) begin
        rdata_q <= M_AXI_RDATA;
        resp_q  <= M_AXI_RRESP;
      end
    end
  end

`ifdef AXIL_ERRCNT_EN
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN)
      err_count <= '0;
    else if (((b_hs && M_AXI_BRESP != 2'b00) || (r_hs && M_AXI_RRESP != 2'b00)) &&
             (err_count != {ERRCNT_WIDTH{1'b1}}))
      err_count <= err_count + 1'b1;
  end
`endif

  assign cmd_ready     = (state == IDLE);
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rdata_q;
  assign rsp_resp      = resp_q;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;

endmodule
